// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, field offsets and packing helpers for the MIPS
// inter-stage pipeline registers.
//   ID/EX payload : {d1[31:0], d2[31:0], rs[4:0], rt[4:0], rd[4:0]}  (79 bits)
//   ID/EX control : {muxctrl[15:0], memctrl[2:0], aluctrl[3:0]}       (23 bits)
package pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned MUXCTRL_W  = 16;
    localparam int unsigned MEMCTRL_W  = 3;
    localparam int unsigned ALUCTRL_W  = 4;

    localparam int unsigned ID_EX_DATA_W = 2 * WORD_W + 3 * REG_ADDR_W;
    localparam int unsigned ID_EX_CTRL_W = MUXCTRL_W + MEMCTRL_W + ALUCTRL_W;

    // Payload field offsets (LSB positions), rd in the low bits.
    localparam int unsigned RD_LSB = 0;
    localparam int unsigned RT_LSB = RD_LSB + REG_ADDR_W;
    localparam int unsigned RS_LSB = RT_LSB + REG_ADDR_W;
    localparam int unsigned D2_LSB = RS_LSB + REG_ADDR_W;
    localparam int unsigned D1_LSB = D2_LSB + WORD_W;

    // Control field offsets (LSB positions), aluctrl in the low bits.
    localparam int unsigned ALUCTRL_LSB = 0;
    localparam int unsigned MEMCTRL_LSB = ALUCTRL_LSB + ALUCTRL_W;
    localparam int unsigned MUXCTRL_LSB = MEMCTRL_LSB + MEMCTRL_W;

    typedef struct packed {
        logic [WORD_W-1:0]     d1;
        logic [WORD_W-1:0]     d2;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
    } id_ex_data_t;

    typedef struct packed {
        logic [MUXCTRL_W-1:0] muxctrl;
        logic [MEMCTRL_W-1:0] memctrl;
        logic [ALUCTRL_W-1:0] aluctrl;
    } id_ex_ctrl_t;

    function automatic logic [ID_EX_DATA_W-1:0] pack_id_ex_data(
        input logic [WORD_W-1:0]     d1,
        input logic [WORD_W-1:0]     d2,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rt,
        input logic [REG_ADDR_W-1:0] rd
    );
        logic [ID_EX_DATA_W-1:0] v;
        v = '0;
        v[D1_LSB +: WORD_W]     = d1;
        v[D2_LSB +: WORD_W]     = d2;
        v[RS_LSB +: REG_ADDR_W] = rs;
        v[RT_LSB +: REG_ADDR_W] = rt;
        v[RD_LSB +: REG_ADDR_W] = rd;
        return v;
    endfunction

    function automatic logic [ID_EX_CTRL_W-1:0] pack_id_ex_ctrl(
        input logic [MUXCTRL_W-1:0] muxctrl,
        input logic [MEMCTRL_W-1:0] memctrl,
        input logic [ALUCTRL_W-1:0] aluctrl
    );
        logic [ID_EX_CTRL_W-1:0] v;
        v = '0;
        v[MUXCTRL_LSB +: MUXCTRL_W] = muxctrl;
        v[MEMCTRL_LSB +: MEMCTRL_W] = memctrl;
        v[ALUCTRL_LSB +: ALUCTRL_W] = aluctrl;
        return v;
    endfunction

endpackage

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: inter-stage pipeline register with valid/ready handshake,
// stall back-pressure, flush and bubble insertion.
//   clock, reset        rising-edge clock, synchronous active-high reset
//   flush               drop every held entry (and any item accepted this cycle)
//   in_valid/in_ready   upstream handshake, in_data/in_ctrl payload
//   out_valid/out_ready downstream handshake, out_data/out_ctrl presented item
//   occupancy           number of held entries (0..1+SKID)
// SKID=1 adds a second entry so in_ready comes straight from a flop;
// SKID=0 is a single entry with in_ready = !main_valid | out_ready.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = ID_EX_DATA_W,
    parameter int unsigned CTRL_W = ID_EX_CTRL_W,
    parameter int unsigned SKID   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;

    logic              skid_valid_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;

    logic in_xfer;
    logic load_main;

    assign in_xfer   = in_valid & in_ready;
    assign load_main = ~main_valid_q | out_ready;

    // Main entry: the skid entry (older) has priority over fresh input so
    // items leave in arrival order. Loading with no source makes a bubble,
    // and a bubble always carries zero control.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
        end else if (load_main) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_ctrl_d  = skid_ctrl_q;
            end else if (in_xfer) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
                main_ctrl_d  = in_ctrl;
            end else begin
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid_d;
            logic [DATA_W-1:0] skid_data_d;
            logic [CTRL_W-1:0] skid_ctrl_d;
            logic              in_ready_q;

            // The skid entry only fills when main is held by a stall; any
            // main load empties it, since main takes the skid item first.
            always_comb begin
                skid_valid_d = skid_valid_q;
                skid_data_d  = skid_data_q;
                skid_ctrl_d  = skid_ctrl_q;
                if (flush || load_main) begin
                    skid_valid_d = 1'b0;
                end else if (in_xfer) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data;
                    skid_ctrl_d  = in_ctrl;
                end
            end

            // in_ready is its own flop tracking the next skid state, so
            // out_ready never reaches in_ready combinationally.
            always_ff @(posedge clock) begin
                if (reset) begin
                    skid_valid_q <= 1'b0;
                    skid_data_q  <= '0;
                    skid_ctrl_q  <= '0;
                    in_ready_q   <= 1'b1;
                end else begin
                    skid_valid_q <= skid_valid_d;
                    skid_data_q  <= skid_data_d;
                    skid_ctrl_q  <= skid_ctrl_d;
                    in_ready_q   <= ~skid_valid_d;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_no_skid
            assign skid_valid_q = 1'b0;
            assign skid_data_q  = '0;
            assign skid_ctrl_q  = '0;
            assign in_ready     = ~main_valid_q | out_ready;
        end
    endgenerate

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: one SKID=1 instance (s_*) and one SKID=0
// instance (z_*), sharing clock and reset, each with a data/ctrl scoreboard.
module tb_pipe_stage_hs;
    import pipe_pkg::*;

    localparam int unsigned DW = ID_EX_DATA_W;
    localparam int unsigned CW = ID_EX_CTRL_W;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } item_t;

    logic clock = 1'b0;
    logic reset;

    logic          s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [DW-1:0] s_in_data, s_out_data;
    logic [CW-1:0] s_in_ctrl, s_out_ctrl;
    logic [1:0]    s_occ;

    logic          z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
    logic [DW-1:0] z_in_data, z_out_data;
    logic [CW-1:0] z_in_ctrl, z_out_ctrl;
    logic [1:0]    z_occ;

    item_t s_q[$];
    item_t z_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_skid (
        .clock(clock), .reset(reset), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_ctrl(s_in_ctrl),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .occupancy(s_occ)
    );

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_noskid (
        .clock(clock), .reset(reset), .flush(z_flush),
        .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_data(z_in_data), .in_ctrl(z_in_ctrl),
        .out_valid(z_out_valid), .out_ready(z_out_ready),
        .out_data(z_out_data), .out_ctrl(z_out_ctrl),
        .occupancy(z_occ)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard one side just before the edge: compare whatever leaves,
    // enqueue whatever is accepted; reset/flush discard everything in flight.
    task automatic sb_step(input string side, input logic fl,
                           input logic iv, input logic ir, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                           input logic ov, input logic orr, input logic [DW-1:0] od, input logic [CW-1:0] oc);
        item_t e;
        if (side == "s") begin
            if (reset || fl) s_q.delete();
            else begin
                if (ov && orr) begin
                    if (s_q.size() == 0) check("s_unexpected_out", 128'(od), 128'hDEAD);
                    else begin
                        e = s_q.pop_front();
                        check("s_sb_data", 128'(od), 128'(e.data));
                        check("s_sb_ctrl", 128'(oc), 128'(e.ctrl));
                    end
                end
                if (iv && ir) s_q.push_back('{data: id, ctrl: ic});
            end
        end else begin
            if (reset || fl) z_q.delete();
            else begin
                if (ov && orr) begin
                    if (z_q.size() == 0) check("z_unexpected_out", 128'(od), 128'hDEAD);
                    else begin
                        e = z_q.pop_front();
                        check("z_sb_data", 128'(od), 128'(e.data));
                        check("z_sb_ctrl", 128'(oc), 128'(e.ctrl));
                    end
                end
                if (iv && ir) z_q.push_back('{data: id, ctrl: ic});
            end
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next.
    task automatic tick();
        #2;
        sb_step("s", s_flush, s_in_valid, s_in_ready, s_in_data, s_in_ctrl,
                s_out_valid, s_out_ready, s_out_data, s_out_ctrl);
        sb_step("z", z_flush, z_in_valid, z_in_ready, z_in_data, z_in_ctrl,
                z_out_valid, z_out_ready, z_out_data, z_out_ctrl);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_in_ctrl = '0; s_out_ready = 1'b0;
        z_flush = 1'b0; z_in_valid = 1'b0; z_in_data = '0; z_in_ctrl = '0; z_out_ready = 1'b0;
        @(posedge clock); #1;
        tick();

        // Reset state
        check("rst_out_valid", 128'(s_out_valid), 128'd0);
        check("rst_out_ctrl",  128'(s_out_ctrl),  128'd0);
        check("rst_out_data",  128'(s_out_data),  128'd0);
        check("rst_occ",       128'(s_occ),       128'd0);
        check("rst_in_ready",  128'(s_in_ready),  128'd1);
        check("rst_z_occ",     128'(z_occ),       128'd0);
        reset = 1'b0;

        // Streaming 1..8, one per cycle, 1-cycle latency
        s_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = DW'(i);
            s_in_ctrl  = CW'(i * 3);
            tick();
            check("stream_valid", 128'(s_out_valid), 128'd1);
            check("stream_data",  128'(s_out_data),  128'(i));
            check("stream_rdy",   128'(s_in_ready),  128'd1);
        end
        s_in_valid = 1'b0;
        tick();
        check("stream_drain_valid", 128'(s_out_valid), 128'd0);
        check("stream_drain_occ",   128'(s_occ),       128'd0);

        // Stall and skid
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = DW'('hA); s_in_ctrl = CW'('h1A);
        tick();
        check("stall_occ1", 128'(s_occ), 128'd1);
        s_in_data = DW'('hB); s_in_ctrl = CW'('h1B);
        tick();
        check("stall_occ2",    128'(s_occ),      128'd2);
        check("stall_rdy0",    128'(s_in_ready), 128'd0);
        check("stall_data_a",  128'(s_out_data), 128'hA);
        s_in_data = DW'('hDD); s_in_ctrl = CW'('h1D);
        tick();
        check("full_occ",      128'(s_occ),       128'd2);
        check("full_valid",    128'(s_out_valid), 128'd1);
        check("full_hold_dat", 128'(s_out_data),  128'hA);
        check("full_hold_ctl", 128'(s_out_ctrl),  128'h1A);
        s_in_valid = 1'b0;
        s_out_ready = 1'b1;
        tick();
        check("drain_data_b",  128'(s_out_data), 128'hB);
        check("drain_ctrl_b",  128'(s_out_ctrl), 128'h1B);
        check("drain_occ1",    128'(s_occ),      128'd1);
        check("drain_rdy1",    128'(s_in_ready), 128'd1);
        tick();
        check("drain_empty",   128'(s_out_valid), 128'd0);

        // Flush with both entries full (input refused)
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = DW'('hE1); s_in_ctrl = CW'('h21);
        tick();
        s_in_data = DW'('hE2); s_in_ctrl = CW'('h22);
        tick();
        check("flush_pre_occ", 128'(s_occ), 128'd2);
        s_flush = 1'b1; s_in_data = DW'('hC); s_in_ctrl = CW'('h2C);
        tick();
        s_flush = 1'b0; s_in_valid = 1'b0;
        check("flush_valid", 128'(s_out_valid), 128'd0);
        check("flush_ctrl",  128'(s_out_ctrl),  128'd0);
        check("flush_occ",   128'(s_occ),       128'd0);
        check("flush_rdy",   128'(s_in_ready),  128'd1);
        s_out_ready = 1'b1;
        tick();
        tick();
        check("flush_no_c", 128'(s_out_valid), 128'd0);

        // Flush with one entry: concurrent input accepted then discarded
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = DW'('hF1); s_in_ctrl = CW'('h31);
        tick();
        s_flush = 1'b1; s_in_data = DW'('hC3); s_in_ctrl = CW'('h33);
        tick();
        s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        check("flush1_occ", 128'(s_occ), 128'd0);
        tick();
        check("flush1_no_c", 128'(s_out_valid), 128'd0);

        // Bubble control zeroing
        s_in_valid = 1'b1;
        s_in_data = pack_id_ex_data(32'h1234_5678, 32'h9ABC_DEF0, 5'd1, 5'd2, 5'd3);
        s_in_ctrl = pack_id_ex_ctrl(16'hFFFF, 3'h7, 4'hF);
        tick();
        check("bub_ctrl_full", 128'(s_out_ctrl), 128'h7FFFFF);
        s_in_valid = 1'b0;
        tick();
        check("bub_ctrl_zero", 128'(s_out_ctrl),  128'd0);
        check("bub_valid",     128'(s_out_valid), 128'd0);

        // Reset mid-stream with both entries full
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = DW'('h11); s_in_ctrl = CW'('h41);
        tick();
        s_in_data = DW'('h22); s_in_ctrl = CW'('h42);
        tick();
        check("mid_pre_occ", 128'(s_occ), 128'd2);
        s_in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_valid", 128'(s_out_valid), 128'd0);
        check("mid_ctrl",  128'(s_out_ctrl),  128'd0);
        check("mid_occ",   128'(s_occ),       128'd0);
        check("mid_rdy",   128'(s_in_ready),  128'd1);

        // SKID=0: combinational in_ready and replace-on-transfer
        z_out_ready = 1'b0;
        z_in_valid = 1'b1; z_in_data = DW'('h4); z_in_ctrl = CW'('h44);
        #1;
        check("z_rdy_empty", 128'(z_in_ready), 128'd1);
        tick();
        z_in_data = DW'('h5); z_in_ctrl = CW'('h45);
        #1;
        check("z_rdy_stall", 128'(z_in_ready), 128'd0);
        tick();
        check("z_hold_data", 128'(z_out_data), 128'h4);
        check("z_hold_occ",  128'(z_occ),      128'd1);
        z_out_ready = 1'b1;
        #1;
        check("z_rdy_comb", 128'(z_in_ready), 128'd1);
        tick();
        check("z_replace_data",  128'(z_out_data),  128'h5);
        check("z_replace_valid", 128'(z_out_valid), 128'd1);
        for (int i = 6; i <= 9; i++) begin
            z_in_data = DW'(i); z_in_ctrl = CW'(i + 'h40);
            tick();
            check("z_stream_data", 128'(z_out_data), 128'(i));
            check("z_stream_occ",  128'(z_occ),      128'd1);
        end
        z_in_valid = 1'b0;
        tick();
        check("z_empty", 128'(z_out_valid), 128'd0);
        check("z_empty_ctrl", 128'(z_out_ctrl), 128'd0);

        check("s_q_empty", 128'(s_q.size()), 128'd0);
        check("z_q_empty", 128'(z_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
